// File: rtl/axis_loader_pkg.sv
// Shared constants for the AXI-Stream BRAM loader: FSM encodings, header
// layout and the default magic word.
package axis_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR1  = 3'd1;
    localparam logic [2:0] ST_HDR2  = 3'd2;
    localparam logic [2:0] ST_HDR3  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    localparam logic [15:0] DEFAULT_MAGIC = 16'hC0DE;

    localparam int NUM_BRAMS_MSB  = 15;
    localparam int NUM_BRAMS_LSB  = 8;
    localparam int FIRST_BRAM_MSB = 7;
    localparam int FIRST_BRAM_LSB = 0;

    localparam int PAYLOAD_CNT_W = 20;

endpackage

// File: rtl/loader_addr_gen.sv
// Lane/address sequencer for the payload phase: walks lane-major through
// first_lane..first_lane+num-1, each over start_addr..start_addr+L-1.
module loader_addr_gen
    import axis_loader_pkg::*;
#(
    parameter int BRAM_COUNT = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LANE_W     = $clog2(BRAM_COUNT)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic [LANE_W-1:0]        i_first_lane,
    input  logic [ADDR_WIDTH-1:0]    i_start_addr,
    input  logic [ADDR_WIDTH:0]      i_words_per_bram,
    input  logic [PAYLOAD_CNT_W-1:0] i_total_words,
    output logic [LANE_W-1:0]        o_lane,
    output logic [ADDR_WIDTH-1:0]    o_addr,
    output logic                     o_last
);

    logic [LANE_W-1:0]        r_lane;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_start;
    logic [ADDR_WIDTH-1:0]    r_end;
    logic [PAYLOAD_CNT_W-1:0] r_remaining;
    logic [ADDR_WIDTH:0]      w_end_full;

    // Header is validated before load, so start+L-1 always fits the address.
    assign w_end_full = {1'b0, i_start_addr} + i_words_per_bram - {{ADDR_WIDTH{1'b0}}, 1'b1};

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_lane      <= '0;
            r_addr      <= '0;
            r_start     <= '0;
            r_end       <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_lane      <= i_first_lane;
            r_addr      <= i_start_addr;
            r_start     <= i_start_addr;
            r_end       <= w_end_full[ADDR_WIDTH-1:0];
            r_remaining <= i_total_words - PAYLOAD_CNT_W'(1);
        end else if (i_step) begin
            if (r_addr == r_end) begin
                r_addr <= r_start;
                r_lane <= r_lane + LANE_W'(1);
            end else begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (r_remaining != '0)
                r_remaining <= r_remaining - PAYLOAD_CNT_W'(1);
        end
    end

    assign o_lane = r_lane;
    assign o_addr = r_addr;
    assign o_last = (r_remaining == '0);

endmodule

// File: rtl/axis_bram_loader.sv
// AXI-Stream ingress loader: parses a 4-word header and writes the payload
// lane-major into a bank of BRAMs, flagging magic and length errors.
module axis_bram_loader
    import axis_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    BRAM_COUNT = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    BRAM_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] MAGIC      = DEFAULT_MAGIC
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [BRAM_COUNT*DATA_WIDTH-1:0] bram_wr_data_flat,
    output logic [ADDR_WIDTH-1:0]            bram_wr_addr,
    output logic [BRAM_COUNT-1:0]            bram_wr_en,
    output logic                             write_done,
    output logic                             error_invalid_magic,
    output logic                             error_length,
    output logic [2:0]                       parser_state
);

    localparam int LANE_W = $clog2(BRAM_COUNT);
    localparam int SUM_W  = DATA_WIDTH + 1;

    logic                             r_tready;
    logic [2:0]                       r_state;
    logic [7:0]                       r_num_brams;
    logic [7:0]                       r_first_bram;
    logic [ADDR_WIDTH-1:0]            r_start_addr;
    logic [BRAM_COUNT*DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0]            r_wr_addr;
    logic [BRAM_COUNT-1:0]            r_wr_en;
    logic                             r_write_done;
    logic                             r_err_magic;
    logic                             r_err_length;

    logic                     w_hs;
    logic [8:0]               w_lane_sum;
    logic [SUM_W-1:0]         w_addr_sum;
    logic                     w_hdr_bad;
    logic [PAYLOAD_CNT_W-1:0] w_total;
    logic                     w_load;
    logic                     w_step;
    logic [LANE_W-1:0]        w_lane;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic                     w_last;
    logic [BRAM_COUNT-1:0]    w_lane_onehot;

    assign w_hs = s_axis_tvalid & r_tready;

    // Sums are one bit wider than their operands so out-of-range headers cannot alias.
    assign w_lane_sum = {1'b0, r_first_bram} + {1'b0, r_num_brams};
    assign w_addr_sum = SUM_W'(r_start_addr) + SUM_W'(s_axis_tdata);
    assign w_hdr_bad  = (r_num_brams == '0) || (s_axis_tdata == '0) ||
                        (w_lane_sum > 9'(BRAM_COUNT)) || (w_addr_sum > SUM_W'(BRAM_DEPTH));
    assign w_total    = PAYLOAD_CNT_W'(r_num_brams) * PAYLOAD_CNT_W'(s_axis_tdata);

    assign w_load = w_hs && (r_state == ST_HDR3) && !s_axis_tlast && !w_hdr_bad;
    assign w_step = w_hs && (r_state == ST_DATA);

    loader_addr_gen #(
        .BRAM_COUNT (BRAM_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_W     (LANE_W)
    ) u_addr_gen (
        .aclk             (aclk),
        .areset           (areset),
        .i_load           (w_load),
        .i_step           (w_step),
        .i_first_lane     (r_first_bram[LANE_W-1:0]),
        .i_start_addr     (r_start_addr),
        .i_words_per_bram (s_axis_tdata[ADDR_WIDTH:0]),
        .i_total_words    (w_total),
        .o_lane           (w_lane),
        .o_addr           (w_addr),
        .o_last           (w_last)
    );

    assign w_lane_onehot = {{(BRAM_COUNT-1){1'b0}}, 1'b1} << w_lane;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_tready     <= 1'b0;
            r_state      <= ST_IDLE;
            r_num_brams  <= '0;
            r_first_bram <= '0;
            r_start_addr <= '0;
            r_wr_data    <= '0;
            r_wr_addr    <= '0;
            r_wr_en      <= '0;
            r_write_done <= 1'b0;
            r_err_magic  <= 1'b0;
            r_err_length <= 1'b0;
        end else begin
            r_tready     <= 1'b1;
            r_wr_en      <= '0;
            r_write_done <= 1'b0;
            if (w_hs) begin
                case (r_state)
                    ST_IDLE: begin
                        if (s_axis_tdata == MAGIC) begin
                            r_state      <= ST_HDR1;
                            r_err_magic  <= 1'b0;
                            r_err_length <= 1'b0;
                        end else begin
                            r_err_magic <= 1'b1;
                            r_state     <= s_axis_tlast ? ST_IDLE : ST_DRAIN;
                        end
                    end
                    ST_HDR1: begin
                        if (s_axis_tlast) begin
                            r_err_length <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_num_brams  <= s_axis_tdata[NUM_BRAMS_MSB:NUM_BRAMS_LSB];
                            r_first_bram <= s_axis_tdata[FIRST_BRAM_MSB:FIRST_BRAM_LSB];
                            r_state      <= ST_HDR2;
                        end
                    end
                    ST_HDR2: begin
                        if (s_axis_tlast) begin
                            r_err_length <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_start_addr <= s_axis_tdata[ADDR_WIDTH-1:0];
                            r_state      <= ST_HDR3;
                        end
                    end
                    ST_HDR3: begin
                        if (s_axis_tlast) begin
                            r_err_length <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (w_hdr_bad) begin
                            r_err_length <= 1'b1;
                            r_state      <= ST_DRAIN;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_wr_en   <= w_lane_onehot;
                        r_wr_addr <= w_addr;
                        r_wr_data <= {BRAM_COUNT{s_axis_tdata}};
                        if (w_last) begin
                            r_write_done <= 1'b1;
                            if (s_axis_tlast) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_err_length <= 1'b1;
                                r_state      <= ST_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            r_err_length <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_axis_tlast)
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_axis_tready       = r_tready;
    assign bram_wr_data_flat   = r_wr_data;
    assign bram_wr_addr        = r_wr_addr;
    assign bram_wr_en          = r_wr_en;
    assign write_done          = r_write_done;
    assign error_invalid_magic = r_err_magic;
    assign error_length        = r_err_length;
    assign parser_state        = r_state;

endmodule

// File: tb/tb_axis_bram_loader.sv
// Directed, table-driven bench: each record is one stream word plus the
// registered outputs expected right after that word is accepted.
module tb_axis_bram_loader;

    logic         aclk;
    logic         areset;
    logic [15:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] bram_wr_data_flat;
    logic [9:0]   bram_wr_addr;
    logic [15:0]  bram_wr_en;
    logic         write_done;
    logic         error_invalid_magic;
    logic         error_length;
    logic [2:0]   parser_state;

    axis_bram_loader dut (
        .aclk                (aclk),
        .areset              (areset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tready       (s_axis_tready),
        .bram_wr_data_flat   (bram_wr_data_flat),
        .bram_wr_addr        (bram_wr_addr),
        .bram_wr_en          (bram_wr_en),
        .write_done          (write_done),
        .error_invalid_magic (error_invalid_magic),
        .error_length        (error_length),
        .parser_state        (parser_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] en;
        logic [9:0]  addr;
        logic        done;
        logic [2:0]  st;
        logic        em;
        logic        el;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] data, input logic last, input logic [15:0] en,
                       input logic [9:0] addr, input logic done, input logic [2:0] st,
                       input logic em, input logic el);
        vec_t v;
        v.data = data; v.last = last; v.en = en; v.addr = addr;
        v.done = done; v.st = st; v.em = em; v.el = el;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        logic [63:0] act;
        logic [63:0] exp;
        logic        data_ok;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge aclk);
            s_axis_tdata  = vecs[i].data;
            s_axis_tlast  = vecs[i].last;
            s_axis_tvalid = 1'b1;
            @(posedge aclk);
            #1;
            data_ok = (vecs[i].en == '0) || (bram_wr_data_flat == {16{vecs[i].data}});
            act = {30'd0, bram_wr_en, (vecs[i].en != '0) ? bram_wr_addr : 10'd0, write_done,
                   parser_state, error_invalid_magic, error_length, s_axis_tready, data_ok};
            exp = {30'd0, vecs[i].en, (vecs[i].en != '0) ? vecs[i].addr : 10'd0, vecs[i].done,
                   vecs[i].st, vecs[i].em, vecs[i].el, 1'b1, 1'b1};
            check($sformatf("%s[%0d] en/addr/done/st/em/el/rdy/data", tag, i), act, exp);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        vecs.delete();
    endtask

    function automatic logic [63:0] idle_snapshot();
        return {30'd0, s_axis_tready, bram_wr_en, bram_wr_addr, write_done, parser_state,
                error_invalid_magic, error_length, |bram_wr_data_flat};
    endfunction

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #2;
        check("reset_state", idle_snapshot(), 64'd0);
        #20;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("tready_after_release", {63'd0, s_axis_tready}, 64'd1);

        // Valid packet: 2 lanes from lane 0, addr 5, L=3, payload 1..6.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0200, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h0005, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0003, 0, 16'h0000, 0, 0, 3'd4, 0, 0);
        add(16'h0001, 0, 16'h0001, 5, 0, 3'd4, 0, 0);
        add(16'h0002, 0, 16'h0001, 6, 0, 3'd4, 0, 0);
        add(16'h0003, 0, 16'h0001, 7, 0, 3'd4, 0, 0);
        add(16'h0004, 0, 16'h0002, 5, 0, 3'd4, 0, 0);
        add(16'h0005, 0, 16'h0002, 6, 0, 3'd4, 0, 0);
        add(16'h0006, 1, 16'h0002, 7, 1, 3'd0, 0, 0);
        // Bad magic on a single-word packet stays in IDLE.
        add(16'h1234, 1, 16'h0000, 0, 0, 3'd0, 1, 0);
        // Bad magic followed by 10 words, tlast on the last one.
        add(16'hBEEF, 0, 16'h0000, 0, 0, 3'd5, 1, 0);
        for (int i = 0; i < 9; i++)
            add(16'h0100 + 16'(i), 0, 16'h0000, 0, 0, 3'd5, 1, 0);
        add(16'h0109, 1, 16'h0000, 0, 0, 3'd0, 1, 0);
        // Upper-boundary valid packet: lane 15, addr 1022, L=2; clears the magic flag.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h010F, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h03FE, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0002, 0, 16'h0000, 0, 0, 3'd4, 0, 0);
        add(16'hAAAA, 0, 16'h8000, 10'h3FE, 0, 3'd4, 0, 0);
        add(16'hBBBB, 1, 16'h8000, 10'h3FF, 1, 3'd0, 0, 0);
        run_vecs("basic");

        // first_bram=14, num_brams=3 exceeds the bank.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h030E, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h0000, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0001, 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        add(16'h0011, 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        add(16'h0022, 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        add(16'h0033, 1, 16'h0000, 0, 0, 3'd0, 0, 1);
        // start_addr=1020, L=8 runs past the BRAM depth.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0101, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h03FC, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0008, 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        for (int i = 0; i < 7; i++)
            add(16'h5000 + 16'(i), 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        add(16'h5007, 1, 16'h0000, 0, 0, 3'd0, 0, 1);
        // tlast on a header word.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0200, 1, 16'h0000, 0, 0, 3'd0, 0, 1);
        // Header for 8 words, tlast on word 5: five strobes, no write_done.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0100, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h0000, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0008, 0, 16'h0000, 0, 0, 3'd4, 0, 0);
        for (int i = 0; i < 4; i++)
            add(16'h7000 + 16'(i), 0, 16'h0001, 10'(i), 0, 3'd4, 0, 0);
        add(16'h7004, 1, 16'h0001, 4, 0, 3'd0, 0, 1);
        // Header for 4 words on lane 4 at addr 16, then two extra words.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0104, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h0010, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0004, 0, 16'h0000, 0, 0, 3'd4, 0, 0);
        add(16'h9000, 0, 16'h0010, 16, 0, 3'd4, 0, 0);
        add(16'h9001, 0, 16'h0010, 17, 0, 3'd4, 0, 0);
        add(16'h9002, 0, 16'h0010, 18, 0, 3'd4, 0, 0);
        add(16'h9003, 0, 16'h0010, 19, 1, 3'd5, 0, 1);
        add(16'h00E1, 0, 16'h0000, 0, 0, 3'd5, 0, 1);
        add(16'h00E2, 1, 16'h0000, 0, 0, 3'd0, 0, 1);
        run_vecs("errors");

        // Reset after payload word 2 of 6.
        add(16'hC0DE, 0, 16'h0000, 0, 0, 3'd1, 0, 0);
        add(16'h0200, 0, 16'h0000, 0, 0, 3'd2, 0, 0);
        add(16'h0005, 0, 16'h0000, 0, 0, 3'd3, 0, 0);
        add(16'h0003, 0, 16'h0000, 0, 0, 3'd4, 0, 0);
        add(16'h0001, 0, 16'h0001, 5, 0, 3'd4, 0, 0);
        add(16'h0002, 0, 16'h0001, 6, 0, 3'd4, 0, 0);
        run_vecs("pre_reset");
        #2;
        areset = 1'b1;
        #1;
        check("mid_packet_reset", idle_snapshot(), 64'd0);
        @(posedge aclk);
        #1;
        check("held_in_reset", idle_snapshot(), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("tready_after_mid_reset", {63'd0, s_axis_tready}, 64'd1);
        add(16'h0003, 0, 16'h0000, 0, 0, 3'd5, 1, 0);
        add(16'h0004, 0, 16'h0000, 0, 0, 3'd5, 1, 0);
        add(16'h0005, 0, 16'h0000, 0, 0, 3'd5, 1, 0);
        add(16'h0006, 1, 16'h0000, 0, 0, 3'd0, 1, 0);
        run_vecs("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
